// File: rtl/isa_fetch_ctrl.sv
// ISA fetch controller: splits a program into bounded DRAM read bursts and streams the words to the CCU decoder.
// Latency: Start to first read request 2 cycles; return word to decoder valid 1 cycle (FWFT FIFO).
// Backpressure: a burst is requested only when the word FIFO can hold every outstanding word; the decoder stalls the FIFO.

module isa_fetch_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are only observed while count says they are valid, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module isa_fetch_ctrl #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUMWORD_WIDTH   = 16,
    parameter int MAX_BURST       = 16,
    parameter int FIFO_DEPTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          TOPISA_Start,
    input  logic [DRAM_ADDR_WIDTH-1:0]    TOPISA_BaseAddr,
    input  logic [NUMWORD_WIDTH-1:0]      TOPISA_NumWord,
    output logic                          ISAFCH_Busy,
    output logic                          ISAFCH_Done,
    output logic                          ISAFCH_ErrOvf,
    output logic                          ISAITF_RdReqVld,
    input  logic                          ITFISA_RdReqRdy,
    output logic [DRAM_ADDR_WIDTH-1:0]    ISAITF_RdReqAddr,
    output logic [$clog2(MAX_BURST):0]    ISAITF_RdReqLen,
    input  logic [PORT_WIDTH-1:0]         ITFISA_RdDat,
    input  logic                          ITFISA_RdDatVld,
    output logic [PORT_WIDTH-1:0]         ITFCCU_ISARdDat,
    output logic                          ITFCCU_ISARdDatVld,
    output logic                          ITFCCU_ISARdDatLast,
    input  logic                          CCUITF_ISARdDatRdy
);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BYTES = PORT_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                       state;
    state_t                       state_nxt;

    logic [DRAM_ADDR_WIDTH-1:0]   addr;
    logic [NUMWORD_WIDTH-1:0]     req_remain;
    logic [NUMWORD_WIDTH-1:0]     out_remain;
    logic [CNT_W-1:0]             outstanding;
    logic                         req_vld;
    logic                         err_ovf;

    logic [LEN_W-1:0]             cur_len;
    logic [CNT_W-1:0]             free;
    logic                         start_acc;
    logic                         req_fire;
    logic                         ret_ok;
    logic                         ret_bad;
    logic                         out_vld;
    logic                         out_pop;

    logic [PORT_WIDTH-1:0]        fifo_head;
    logic                         fifo_empty;
    logic [CNT_W-1:0]             fifo_count;

    // Word FIFO between the DRAM return channel and the decoder.
    isa_fetch_fifo #(
        .WIDTH (PORT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ret_ok),
        .push_dat (ITFISA_RdDat),
        .pop      (out_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign start_acc = (state == IDLE) && TOPISA_Start;
    assign req_fire  = req_vld && ITFISA_RdReqRdy;
    // A return word is only legal while words are owed to us by an active program.
    assign ret_ok    = ITFISA_RdDatVld && (outstanding != '0) &&
                       ((state == REQ) || (state == DRAIN));
    assign ret_bad   = ITFISA_RdDatVld && !ret_ok;
    assign out_vld   = !fifo_empty;
    assign out_pop   = out_vld && CCUITF_ISARdDatRdy;

    // Credit left in the FIFO once every already-requested word has landed.
    assign free = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding;

    // Burst length for the next request: the remainder, capped at MAX_BURST.
    always_comb begin
        cur_len = LEN_W'(MAX_BURST);
        if (req_remain < NUMWORD_WIDTH'(MAX_BURST)) begin
            cur_len = req_remain[LEN_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        state_nxt   = state;
        ISAFCH_Busy = 1'b0;
        ISAFCH_Done = 1'b0;
        case (state)
            IDLE: begin
                if (TOPISA_Start) begin
                    state_nxt = (TOPISA_NumWord != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                ISAFCH_Busy = 1'b1;
                if (req_fire && (req_remain == NUMWORD_WIDTH'(cur_len))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                ISAFCH_Busy = 1'b1;
                if ((outstanding == '0) && fifo_empty && (out_remain == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ISAFCH_Done = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request address and remaining request count; advance on every accepted burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            req_remain <= '0;
        end else if (start_acc) begin
            addr       <= TOPISA_BaseAddr;
            req_remain <= TOPISA_NumWord;
        end else if (req_fire) begin
            addr       <= addr + DRAM_ADDR_WIDTH'(cur_len) * DRAM_ADDR_WIDTH'(BYTES);
            req_remain <= req_remain - NUMWORD_WIDTH'(cur_len);
        end
    end

    // Request valid: raised only with enough credit, held until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld <= 1'b0;
        end else if (req_fire) begin
            req_vld <= 1'b0;
        end else if ((state == REQ) && !req_vld && (req_remain != '0) &&
                     (free >= CNT_W'(cur_len))) begin
            req_vld <= 1'b1;
        end
    end

    // Words requested but not yet returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, ret_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(cur_len);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                2'b11:   outstanding <= outstanding + CNT_W'(cur_len) - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Words still to be handed to the decoder; drives the Last marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_remain <= '0;
        end else if (start_acc) begin
            out_remain <= TOPISA_NumWord;
        end else if (out_pop) begin
            out_remain <= out_remain - NUMWORD_WIDTH'(1);
        end
    end

    // Sticky overflow flag; an unexpected word wins over a same-cycle Start clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
        end else if (ret_bad) begin
            err_ovf <= 1'b1;
        end else if (start_acc) begin
            err_ovf <= 1'b0;
        end
    end

    assign ISAFCH_ErrOvf       = err_ovf;
    assign ISAITF_RdReqVld     = req_vld;
    assign ISAITF_RdReqAddr    = addr;
    assign ISAITF_RdReqLen     = cur_len;
    assign ITFCCU_ISARdDatVld  = out_vld;
    // Data is forced to zero while no word is valid so idle outputs read as zero.
    assign ITFCCU_ISARdDat     = out_vld ? fifo_head : '0;
    assign ITFCCU_ISARdDatLast = out_vld && (out_remain == NUMWORD_WIDTH'(1));
endmodule

// File: tb/tb_isa_fetch_ctrl.sv
// Bench for isa_fetch_ctrl: random handshakes against a queue-based DRAM and decoder model.
// Expected requests come from splitting the program into MAX_BURST chunks; expected words from their byte addresses.
// Inputs driven at the falling edge; events that commit at the next rising edge are scored at the same time.

module tb_isa_fetch_ctrl;
    localparam int PW = 128;
    localparam int AW = 32;
    localparam int NW = 16;
    localparam int MB = 16;
    localparam int FD = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          TOPISA_Start;
    logic [AW-1:0] TOPISA_BaseAddr;
    logic [NW-1:0] TOPISA_NumWord;
    logic          ISAFCH_Busy;
    logic          ISAFCH_Done;
    logic          ISAFCH_ErrOvf;
    logic          ISAITF_RdReqVld;
    logic          ITFISA_RdReqRdy;
    logic [AW-1:0] ISAITF_RdReqAddr;
    logic [4:0]    ISAITF_RdReqLen;
    logic [PW-1:0] ITFISA_RdDat;
    logic          ITFISA_RdDatVld;
    logic [PW-1:0] ITFCCU_ISARdDat;
    logic          ITFCCU_ISARdDatVld;
    logic          ITFCCU_ISARdDatLast;
    logic          CCUITF_ISARdDatRdy;

    isa_fetch_ctrl #(
        .PORT_WIDTH      (PW),
        .DRAM_ADDR_WIDTH (AW),
        .NUMWORD_WIDTH   (NW),
        .MAX_BURST       (MB),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .TOPISA_Start        (TOPISA_Start),
        .TOPISA_BaseAddr     (TOPISA_BaseAddr),
        .TOPISA_NumWord      (TOPISA_NumWord),
        .ISAFCH_Busy         (ISAFCH_Busy),
        .ISAFCH_Done         (ISAFCH_Done),
        .ISAFCH_ErrOvf       (ISAFCH_ErrOvf),
        .ISAITF_RdReqVld     (ISAITF_RdReqVld),
        .ITFISA_RdReqRdy     (ITFISA_RdReqRdy),
        .ISAITF_RdReqAddr    (ISAITF_RdReqAddr),
        .ISAITF_RdReqLen     (ISAITF_RdReqLen),
        .ITFISA_RdDat        (ITFISA_RdDat),
        .ITFISA_RdDatVld     (ITFISA_RdDatVld),
        .ITFCCU_ISARdDat     (ITFCCU_ISARdDat),
        .ITFCCU_ISARdDatVld  (ITFCCU_ISARdDatVld),
        .ITFCCU_ISARdDatLast (ITFCCU_ISARdDatLast),
        .CCUITF_ISARdDatRdy  (CCUITF_ISARdDatRdy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Content the DRAM model returns for the word at a given byte address.
    function automatic logic [127:0] mkword(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_C3C3, a + 32'h1357_9BDF};
    endfunction

    task automatic idle_inputs();
        TOPISA_Start       = 1'b0;
        TOPISA_BaseAddr    = '0;
        TOPISA_NumWord     = '0;
        ITFISA_RdReqRdy    = 1'b0;
        ITFISA_RdDat       = '0;
        ITFISA_RdDatVld    = 1'b0;
        CCUITF_ISARdDatRdy = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   ISAFCH_Busy, 0);
        chk({tag, "_done"},   ISAFCH_Done, 0);
        chk({tag, "_errovf"}, ISAFCH_ErrOvf, 0);
        chk({tag, "_reqvld"}, ISAITF_RdReqVld, 0);
        chk({tag, "_addr"},   ISAITF_RdReqAddr, 0);
        chk({tag, "_len"},    ISAITF_RdReqLen, 0);
        chk({tag, "_outvld"}, ITFCCU_ISARdDatVld, 0);
        chk({tag, "_outdat"}, ITFCCU_ISARdDat, 0);
        chk({tag, "_last"},   ITFCCU_ISARdDatLast, 0);
    endtask

    // Runs one program. dec_hold forces decoder ready low for that many cycles and then
    // expects hold_reqs bursts to have been accepted; inject_bad drives a stray word at
    // cycle 1; abort_req > 0 returns right after that many requests were accepted.
    task automatic run_prog(input logic [31:0] base, input int num, input int rr_pct,
                            input int ret_pct, input int dec_pct, input int dec_hold,
                            input int hold_reqs, input bit inject_bad, input int abort_req);
        logic [31:0] exp_addr[$];
        int          exp_len[$];
        logic [31:0] pend[$];
        logic [31:0] a;
        logic [31:0] hold_addr;
        logic [4:0]  hold_len;
        bit          hold_pend = 0;
        bit          fin = 0;
        bit          aborted = 0;
        int rem, l;
        int n_req = 0, n_pop = 0, n_done = 0, done_k = -1;
        int first_vld = -1, first_ret = -1, first_out = -1, busy_cnt = 0, words_req = 0;

        rem = num;
        a   = base;
        while (rem > 0) begin
            l = (rem > MB) ? MB : rem;
            exp_addr.push_back(a);
            exp_len.push_back(l);
            a   = a + 32'(l * 16);
            rem = rem - l;
        end

        for (int k = 0; k < 4000 && !fin; k++) begin
            @(negedge clk);
            // Observe the state left by the last rising edge.
            if (hold_pend) begin
                chk("req_hold_vld",  ISAITF_RdReqVld, 1);
                chk("req_hold_addr", ISAITF_RdReqAddr, hold_addr);
                chk("req_hold_len",  ISAITF_RdReqLen, hold_len);
            end
            if (ISAITF_RdReqVld && first_vld < 0) first_vld = k;
            if (ITFCCU_ISARdDatVld && first_out < 0) first_out = k;
            if (ISAFCH_Busy) busy_cnt++;
            if (k == 1) chk("errovf_start_clear", ISAFCH_ErrOvf, 0);
            if (dec_hold > 0 && k == dec_hold) chk("no_req_without_room", n_req, hold_reqs);
            if (k >= 1) begin
                if (done_k >= 0 || ISAFCH_Done) chk("busy_low", ISAFCH_Busy, 0);
                else chk("busy_high", ISAFCH_Busy, (num != 0));
            end
            if (ISAFCH_Done) begin
                n_done++;
                if (done_k < 0) begin
                    done_k = k;
                    chk("words_out", n_pop, num);
                    chk("reqs_left", exp_addr.size(), 0);
                    chk("done_errovf", ISAFCH_ErrOvf, inject_bad);
                end
            end

            // Drive inputs for the next rising edge.
            TOPISA_Start    = (k == 0) || (ISAFCH_Busy && ($urandom_range(7) == 0));
            TOPISA_BaseAddr = (k == 0) ? base : $urandom;
            TOPISA_NumWord  = (k == 0) ? NW'(num) : NW'($urandom);
            ITFISA_RdReqRdy = ($urandom_range(99) < rr_pct);
            if (inject_bad && k == 1) begin
                ITFISA_RdDatVld = 1'b1;
                ITFISA_RdDat    = {$urandom, $urandom, $urandom, $urandom};
            end else if (pend.size() > 0 && $urandom_range(99) < ret_pct) begin
                ITFISA_RdDatVld = 1'b1;
                ITFISA_RdDat    = mkword(pend[0]);
            end else begin
                ITFISA_RdDatVld = 1'b0;
                ITFISA_RdDat    = {$urandom, $urandom, $urandom, $urandom};
            end
            CCUITF_ISARdDatRdy = (k < dec_hold) ? 1'b0 : ($urandom_range(99) < dec_pct);

            // Score the events that commit at the next rising edge.
            hold_pend = 0;
            if (ISAITF_RdReqVld) begin
                if (ITFISA_RdReqRdy) begin
                    if (exp_addr.size() == 0) begin
                        chk("extra_req", 1, 0);
                    end else begin
                        chk("req_addr", ISAITF_RdReqAddr, exp_addr[0]);
                        chk("req_len", ISAITF_RdReqLen, exp_len[0]);
                        chk("fifo_room", (words_req + exp_len[0] - n_pop) <= FD, 1);
                        for (int j = 0; j < exp_len[0]; j++) pend.push_back(exp_addr[0] + 32'(j * 16));
                        words_req += exp_len[0];
                        void'(exp_addr.pop_front());
                        void'(exp_len.pop_front());
                        n_req++;
                    end
                end else begin
                    hold_pend = 1;
                    hold_addr = ISAITF_RdReqAddr;
                    hold_len  = ISAITF_RdReqLen;
                end
            end
            if (ITFISA_RdDatVld && !(inject_bad && k == 1)) begin
                void'(pend.pop_front());
                if (first_ret < 0) first_ret = k;
            end
            if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy) begin
                if (n_pop >= num) begin
                    chk("extra_word", 1, 0);
                end else begin
                    chk("out_dat", ITFCCU_ISARdDat, mkword(base + 32'(n_pop * 16)));
                    chk("out_last", ITFCCU_ISARdDatLast, (n_pop == num - 1));
                end
                n_pop++;
            end
            if (abort_req > 0 && n_req == abort_req) begin
                fin     = 1;
                aborted = 1;
            end
            if (done_k >= 0 && k >= done_k + 3) fin = 1;
        end

        if (!fin) chk("timeout", 0, 1);
        if (fin && !aborted) begin
            chk("done_pulses", n_done, 1);
            if (num == 0) begin
                chk("done_latency", done_k, 1);
                chk("busy_never", busy_cnt, 0);
                chk("no_request", first_vld, -1);
            end else begin
                chk("first_req_latency", first_vld, 2);
                chk("ret_to_out_latency", first_out - first_ret, 1);
            end
        end
    endtask

    initial begin
        logic [31:0] rb;
        int          rn;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run_prog(32'h0000_1000, 40, 100, 100, 100, 0, 0, 0, 0);
        run_prog(32'h0000_1000, 40, 100, 100, 100, 60, 2, 0, 0);
        run_prog(32'hFFFF_FFF0, 2, 100, 100, 100, 0, 0, 0, 0);
        run_prog(32'hFFFF_FFF0, 18, 100, 100, 100, 0, 0, 0, 0);
        run_prog(32'h0000_2000, 0, 100, 100, 100, 0, 0, 0, 0);

        // Stray return word while idle.
        @(negedge clk);
        idle_inputs();
        ITFISA_RdDatVld = 1'b1;
        ITFISA_RdDat    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        ITFISA_RdDatVld = 1'b0;
        chk("idle_stray_errovf", ISAFCH_ErrOvf, 1);
        chk("idle_stray_noword", ITFCCU_ISARdDatVld, 0);
        @(negedge clk);
        chk("errovf_sticky", ISAFCH_ErrOvf, 1);
        chk("idle_stray_noword2", ITFCCU_ISARdDatVld, 0);

        run_prog(32'h0000_3000, 5, 100, 100, 100, 0, 0, 0, 0);
        run_prog(32'h0000_4000, 20, 70, 80, 60, 0, 0, 1, 0);

        // Reset in the middle of the second burst.
        run_prog(32'h0000_1000, 40, 100, 100, 100, 0, 0, 0, 2);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        chk_zero("mid_reset_hold");
        rst = 1'b0;
        run_prog(32'h0000_5000, 3, 100, 100, 100, 0, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            rb = $urandom & 32'hFFFF_FFF0;
            rn = $urandom_range(70, 1);
            run_prog(rb, rn, $urandom_range(100, 30), $urandom_range(100, 30),
                     $urandom_range(100, 30), 0, 0, 0, 0);
        end

        @(negedge clk);
        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
